// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_sub_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// 1-bit gate-level full subtractor: diff = a ^ b ^ b_in,
// b_out = (~a & b) | (~(a ^ b) & b_in).
module fullsub (
   output wire diff,
   output wire b_out,
   input  wire a,
   input  wire b,
   input  wire b_in
);

   wire a_x_b;
   wire a_n;
   wire axb_n;
   wire borrow_gen;
   wire borrow_prop;

   xor g_x1 (a_x_b, a, b);
   xor g_x2 (diff, a_x_b, b_in);
   not g_n1 (a_n, a);
   not g_n2 (axb_n, a_x_b);
   and g_a1 (borrow_gen, a_n, b);
   and g_a2 (borrow_prop, axb_n, b_in);
   or  g_o1 (b_out, borrow_gen, borrow_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - b_in), LSB first, with a
// start/busy/done handshake. SERIAL_SUB_OVERFLOW_EN adds a signed overflow flag.
//
// state    | meaning
// ST_IDLE  | waiting for start; operands captured when start=1
// ST_SHIFT | one bit per cycle through the full-subtractor cell
// ST_DONE  | one-cycle done pulse, result registers valid
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int CW = clog2(WIDTH);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] diff_sr;
   logic [WIDTH-2:0] diff_sr_next;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             br_next;
   logic             last;

   fullsub u_bit (
      .diff  (d),
      .b_out (br_next),
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .b_in  (br)
   );

   // Only the upper WIDTH-1 result bits need storage; the final bit comes
   // straight from the cell on the last shift.
   generate
      if (WIDTH > 2) begin : g_sr_wide
         assign diff_sr_next = {d, diff_sr[WIDTH-2:1]};
      end else begin : g_sr_narrow
         assign diff_sr_next = d;
      end
   endgenerate

   assign last = (cnt == CW'(WIDTH - 1));
   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         diff_sr  <= '0;
         br       <= 1'b0;
         cnt      <= '0;
         diff     <= '0;
         b_out    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         overflow <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  br      <= b_in;
                  cnt     <= '0;
                  diff_sr <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
               br      <= br_next;
               diff_sr <= diff_sr_next;
               if (last) begin
                  diff     <= {d, diff_sr};
                  b_out    <= br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  // borrow into the MSB differs from borrow out of it
                  overflow <= br ^ br_next;
`endif
                  state    <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
